paralelo_serial_tx: RTL and testbench
=====================================

PARALELO_SERIAL_TX -- requirements
Module: paralelo_serial_tx

Interface
REQ-001 The block SHALL have parameter COM_SYM, default 8'hBC, meaning the comma symbol transmitted during training.
REQ-002 The block SHALL have parameter IDLE_SYM, default 8'h7C, meaning the symbol transmitted in RUN when no valid byte is present.
REQ-003 The block SHALL have parameter TRAIN_SYMS, default 4, meaning the number of COM_SYM symbols sent before entering RUN (range 1-15).
REQ-004 The block SHALL have port clk_32f, input, 1 bit: the single clock, 8x the byte rate; all logic is on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: reset is synchronous and active-high.
REQ-006 The block SHALL have port data_in, input, 8 bits: byte from the upstream 32-to-8 byte stage.
REQ-007 The block SHALL have port valid_in, input, 1 bit: data_in holds a byte to send.
REQ-008 The block SHALL have port data_out, output reg, 1 bit: serial bit stream, MSB first.
REQ-009 The block SHALL have port load_out, output reg, 1 bit: one-cycle pulse marking the first bit of each symbol on data_out.
REQ-010 The block SHALL have port active_out, output reg, 1 bit: high while in state RUN.

Function
REQ-011 The block SHALL keep a 3-bit bit counter that increments by 1 every clock, wrapping 7->0.
REQ-012 A load edge SHALL be any rising edge on which the bit counter equals 7; data_in and valid_in SHALL be sampled only on load edges and ignored otherwise.
REQ-013 On a load edge the 8-bit shift register SHALL load the selected symbol; on every other edge it SHALL shift left by one, filling with 0.
REQ-014 data_out SHALL equal shift register bit 7, so the symbol loaded at load edge N is on data_out, MSB first, for the 8 cycles after edges N..N+7.
REQ-015 load_out SHALL be high for exactly the one cycle following each load edge and low otherwise.
REQ-016 The FSM SHALL have two states: TRAIN and RUN.
REQ-017 In TRAIN, every load SHALL select COM_SYM regardless of valid_in, and a 4-bit training counter SHALL increment per load.
REQ-018 On the load edge where the training counter reaches TRAIN_SYMS, the FSM SHALL go to RUN, with active_out high from the next cycle.
REQ-019 In RUN, a load SHALL select data_in if valid_in=1, otherwise IDLE_SYM.
REQ-020 RUN SHALL be left only by reset; the training counter SHALL saturate and not wrap.
REQ-021 A data_in value equal to COM_SYM or IDLE_SYM with valid_in=1 SHALL be sent unmodified.
REQ-022 valid_in toggling between load edges SHALL have no effect; only the value at the load edge matters.

Reset
REQ-023 While reset=1 at a rising edge, the bit counter, shift register, training counter, data_out, load_out and active_out SHALL all go to 0 and the FSM SHALL go to TRAIN.
REQ-024 Reset mid-symbol SHALL discard the partial symbol; the first load after deassertion SHALL occur on the 8th edge with reset=0.
REQ-025 Reset mid-RUN SHALL restart the full training sequence of TRAIN_SYMS COM_SYM symbols.

Verification
REQ-026 Defaults; reset for 2 edges, then valid_in=0 -> data_out=0 for 8 cycles, then 1,0,1,1,1,1,0,0 repeated 4 times, load_out pulses every 8 cycles, active_out rises after the 32nd edge.
REQ-027 After training, valid_in=1, data_in=8'hA5 at the 40th edge -> bits 1,0,1,0,0,1,0,1 follow, with load_out high on the first bit.
REQ-028 In RUN, valid_in=0 at a load edge -> 8'h7C (0,1,1,1,1,1,0,0) is sent; valid_in pulsed high only between load edges -> still 8'h7C.
REQ-029 valid_in=1, data_in=8'hFF during TRAIN -> COM_SYM is still sent and the training count is unchanged.
REQ-030 Reset asserted at bit 3 of a data symbol in RUN -> next cycle all outputs are 0 and active_out=0; after release 4 COM_SYM symbols precede any data.
REQ-031 Back-to-back data 8'h00, 8'hFF, 8'hBC with valid_in=1 -> 24 contiguous bits match, with no gap or idle inserted.

Source files
------------

// File: rtl/paralelo_serial_tx.sv
// Byte-to-serial transmitter for a link running at 8x the byte rate.
// A free-running 3-bit counter defines symbol boundaries. Each symbol is
// loaded into an 8-bit shift register, which then shifts out MSB first.
// After reset the block sends TRAIN_SYMS comma symbols and then enters
// RUN. In RUN it sends the input byte when valid_in is high at a load,
// and an idle symbol otherwise.
module paralelo_serial_tx #(
    parameter logic [7:0] COM_SYM    = 8'hBC,
    parameter logic [7:0] IDLE_SYM   = 8'h7C,
    parameter int         TRAIN_SYMS = 4
) (
    input  logic       clk_32f,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic       valid_in,
    output logic       data_out,
    output logic       load_out,
    output logic       active_out
);

    typedef enum logic {
        ST_TRAIN = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    localparam logic [3:0] TRAIN_TARGET = 4'(TRAIN_SYMS);

    state_t      state_q, state_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic [3:0]  train_cnt_q, train_cnt_d;
    logic        load_q, load_d;

    logic        load_edge;
    logic [3:0]  train_inc;

    // The last bit slot of the current symbol is the moment to fetch the next one
    assign load_edge = (bit_cnt_q == 3'd7);
    assign train_inc = train_cnt_q + 4'd1;

    // FSM state register
    always_ff @(posedge clk_32f) begin
        if (reset) begin
            state_q <= ST_TRAIN;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: leave TRAIN on the load that completes the comma run; RUN is sticky
    always_comb begin
        state_d = state_q;
        if (state_q == ST_TRAIN && load_edge && train_inc == TRAIN_TARGET) begin
            state_d = ST_RUN;
        end
    end

    // FSM outputs
    always_comb begin
        active_out = (state_q == ST_RUN);
    end

    // Datapath next values: bit counter, symbol select/shift, training count, load marker
    always_comb begin
        bit_cnt_d   = bit_cnt_q + 3'd1;
        shift_d     = {shift_q[6:0], 1'b0};
        train_cnt_d = train_cnt_q;
        load_d      = load_edge;
        if (load_edge) begin
            if (state_q == ST_TRAIN) begin
                // Training ignores the upstream byte entirely
                shift_d     = COM_SYM;
                train_cnt_d = train_inc;
            end else if (valid_in) begin
                shift_d = data_in;
            end else begin
                shift_d = IDLE_SYM;
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clk_32f) begin
        if (reset) begin
            bit_cnt_q   <= 3'd0;
            shift_q     <= 8'd0;
            train_cnt_q <= 4'd0;
            load_q      <= 1'b0;
        end else begin
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            train_cnt_q <= train_cnt_d;
            load_q      <= load_d;
        end
    end

    assign data_out = shift_q[7];
    assign load_out = load_q;

endmodule

// File: tb/tb_paralelo_serial_tx.sv
// Testbench for paralelo_serial_tx. The reference model works in terms of
// symbols. It counts edges since reset release, treats every 8th edge as
// a symbol boundary, and computes which symbol is due and which of its
// bits should be on the line.
module tb_paralelo_serial_tx;

    localparam logic [7:0] COM  = 8'hBC;
    localparam logic [7:0] IDLE = 8'h7C;
    localparam int         NTRAIN = 4;

    logic       clk_32f = 1'b0;
    logic       reset;
    logic [7:0] data_in;
    logic       valid_in;
    logic       data_out;
    logic       load_out;
    logic       active_out;

    paralelo_serial_tx #(
        .COM_SYM(COM),
        .IDLE_SYM(IDLE),
        .TRAIN_SYMS(NTRAIN)
    ) dut (
        .clk_32f(clk_32f),
        .reset(reset),
        .data_in(data_in),
        .valid_in(valid_in),
        .data_out(data_out),
        .load_out(load_out),
        .active_out(active_out)
    );

    always #5 clk_32f = ~clk_32f;

    int n_checks = 0;
    int n_fails  = 0;

    // Reference model state
    int         edge_n = 0;
    int         loads = 0;
    bit         have_sym = 1'b0;
    logic [7:0] cur_sym = 8'h00;
    int         idx = 0;
    logic       exp_data, exp_load, exp_active;
    logic       cap[$];

    task automatic check(input string tag, input logic obs, input logic expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fails++;
            $error("FAIL %s edge=%0d observed=%b expected=%b", tag, edge_n, obs, expv);
        end
    endtask

    // One clock edge: update the model from the inputs at the edge, then check outputs
    task automatic step();
        @(posedge clk_32f);
        if (reset) begin
            edge_n   = 0;
            loads    = 0;
            have_sym = 1'b0;
            idx      = 0;
            exp_load = 1'b0;
        end else begin
            edge_n++;
            if (edge_n % 8 == 0) begin
                if (loads < NTRAIN) cur_sym = COM;
                else if (valid_in)  cur_sym = data_in;
                else                cur_sym = IDLE;
                loads++;
                have_sym = 1'b1;
                idx      = 0;
                exp_load = 1'b1;
            end else begin
                exp_load = 1'b0;
                if (have_sym) idx++;
            end
        end
        exp_data   = have_sym ? cur_sym[7 - idx] : 1'b0;
        exp_active = (loads >= NTRAIN);
        #1;
        check("data_out", data_out, exp_data);
        check("load_out", load_out, exp_load);
        check("active_out", active_out, exp_active);
        cap.push_back(data_out);
    endtask

    // Advance until the next edge is a symbol boundary
    task automatic to_load();
        while ((edge_n + 1) % 8 != 0) step();
    endtask

    task automatic check_bits(input string tag, input logic [7:0] syms[], input int zeros);
        logic [7:0] s;
        int         k;
        k = 0;
        for (int i = 0; i < zeros; i++) begin
            check(tag, cap[k], 1'b0);
            k++;
        end
        foreach (syms[j]) begin
            s = syms[j];
            for (int b = 7; b >= 0; b--) begin
                check(tag, cap[k], s[b]);
                k++;
            end
        end
    endtask

    initial begin
        logic [7:0] pat[];
        reset    = 1'b1;
        valid_in = 1'b0;
        data_in  = 8'h00;

        // Reset for two edges; everything must read zero
        step();
        step();

        // Training with valid_in low, then A5 presented at the 40th edge
        reset = 1'b0;
        cap.delete();
        repeat (39) step();
        data_in  = 8'hA5;
        valid_in = 1'b1;
        step();
        valid_in = 1'b0;
        repeat (7) step();
        pat = new[5];
        pat[0] = COM; pat[1] = COM; pat[2] = COM; pat[3] = COM; pat[4] = 8'hA5;
        check_bits("train_then_A5", pat, 7);

        // Idle when valid_in is low at the load, even if it pulses in between
        to_load();
        step();
        step();
        data_in  = 8'h55;
        valid_in = 1'b1;
        step();
        step();
        valid_in = 1'b0;
        to_load();
        cap.delete();
        step();
        repeat (7) step();
        pat = new[1];
        pat[0] = IDLE;
        check_bits("idle_pulse", pat, 0);

        // Back-to-back data with no gaps, including the comma and idle values
        to_load();
        cap.delete();
        valid_in = 1'b1;
        pat = new[3];
        pat[0] = 8'h00; pat[1] = 8'hFF; pat[2] = 8'hBC;
        for (int k = 0; k < 3; k++) begin
            data_in = pat[k];
            repeat (8) step();
        end
        valid_in = 1'b0;
        check_bits("back_to_back", pat, 0);

        // Random traffic in RUN
        repeat (300) begin
            valid_in = 1'($urandom_range(0, 1));
            data_in  = 8'($urandom);
            step();
        end

        // Reset three bits into a data symbol, then retrain with valid_in held high
        to_load();
        valid_in = 1'b1;
        data_in  = 8'h3C;
        step();
        repeat (3) step();
        reset = 1'b1;
        step();
        reset    = 1'b0;
        data_in  = 8'hFF;
        cap.delete();
        repeat (39) step();
        pat = new[4];
        pat[0] = COM; pat[1] = COM; pat[2] = COM; pat[3] = COM;
        check_bits("retrain", pat, 7);

        // Random traffic after retraining
        repeat (200) begin
            valid_in = 1'($urandom_range(0, 1));
            data_in  = 8'($urandom);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
